// File: rtl/strobe_sequencer_pkg.sv
// Shared encodings for the strobe sequencer: FSM states, device codes, decoder block indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package strobe_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] DEV0 = 2'd0;
    localparam logic [1:0] DEV1 = 2'd1;
    localparam logic [1:0] DEV2 = 2'd2;
    localparam logic [1:0] DEV3 = 2'd3;

    // Decoder block 0 produces read strobes, block 1 produces write strobes
    localparam int RD_BLK = 0;
    localparam int WR_BLK = 1;

    // A programmed wait of zero still yields a one-cycle strobe
    function automatic int clamp_wait(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/strobe_wait_counter.sv
// Loadable down-counter that times the strobe phase; flags terminal count of 1.
// Latency: load/decrement take effect on the next rising edge; tc is a decode of the register.
// Backpressure: none; the owning FSM decides when to load and decrement.
module strobe_wait_counter #(
    parameter int WAIT_WIDTH = 3
) (
    input  logic                  Clk,
    input  logic                  Clear_bar,
    input  logic                  i_load,
    input  logic [WAIT_WIDTH-1:0] i_load_val,
    input  logic                  i_dec,
    output logic                  o_tc
);

    logic [WAIT_WIDTH-1:0] r_cnt;

    // Load has priority over decrement; never wrap below zero
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == WAIT_WIDTH'(1));

endmodule

// File: rtl/strobe_sequencer.sv
// Sequences one decoder access: select setup, programmable-length active-low strobe, hold.
// Latency: Done rises N+1 cycles after the accepting edge (N = per-device wait, min 1).
// Backpressure: Busy=1 in SETUP/STROBE; Req is ignored then and must be held until Busy=0.
module strobe_sequencer
    import strobe_sequencer_pkg::*;
#(
    parameter int WAIT_WIDTH = 3,
    parameter int WAIT0      = 1,
    parameter int WAIT1      = 1,
    parameter int WAIT2      = 2,
    parameter int WAIT3      = 3
) (
    input  logic       Clk,
    input  logic       Clear_bar,
    input  logic       Req,
    input  logic [1:0] Dev,
    input  logic       Write,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] Enable_bar,
    output logic [3:0] A_2D
);

    localparam logic [WAIT_WIDTH-1:0] LW0 = WAIT_WIDTH'(clamp_wait(WAIT0));
    localparam logic [WAIT_WIDTH-1:0] LW1 = WAIT_WIDTH'(clamp_wait(WAIT1));
    localparam logic [WAIT_WIDTH-1:0] LW2 = WAIT_WIDTH'(clamp_wait(WAIT2));
    localparam logic [WAIT_WIDTH-1:0] LW3 = WAIT_WIDTH'(clamp_wait(WAIT3));

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_dev;
    logic                  r_write;
    logic                  w_accept;
    logic                  w_tc;
    logic [WAIT_WIDTH-1:0] w_wait_val;
    logic [1:0]            w_dev_nxt;
    logic                  w_write_nxt;
    logic [3:0]            w_a2d_nxt;
    logic [1:0]            w_en_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // A request is only looked at when Busy is low (IDLE or HOLD)
    assign w_accept = ((r_state == IDLE) || (r_state == HOLD)) && Req;

    // Wait count for the latched device
    always_comb begin
        w_wait_val = LW0;
        case (r_dev)
            DEV0:    w_wait_val = LW0;
            DEV1:    w_wait_val = LW1;
            DEV2:    w_wait_val = LW2;
            DEV3:    w_wait_val = LW3;
            default: w_wait_val = LW0;
        endcase
    end

    strobe_wait_counter #(
        .WAIT_WIDTH (WAIT_WIDTH)
    ) u_wait_cnt (
        .Clk        (Clk),
        .Clear_bar  (Clear_bar),
        .i_load     (r_state == SETUP),
        .i_load_val (w_wait_val),
        .i_dec      (r_state == STROBE),
        .o_tc       (w_tc)
    );

    // State register
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? SETUP : IDLE;
            SETUP:   w_next_state = STROBE;
            STROBE:  w_next_state = w_tc ? HOLD : STROBE;
            HOLD:    w_next_state = w_accept ? SETUP : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Next output values, derived from the state being entered so outputs can be registered
    always_comb begin
        w_dev_nxt   = w_accept ? Dev   : r_dev;
        w_write_nxt = w_accept ? Write : r_write;
        w_a2d_nxt   = (w_next_state == SETUP) ? {w_dev_nxt, w_dev_nxt} : A_2D;
        w_en_nxt    = 2'b11;
        if (w_next_state == STROBE) begin
            w_en_nxt = r_write ? 2'b01 : 2'b10;
        end
        w_busy_nxt  = (w_next_state == SETUP) || (w_next_state == STROBE);
        w_done_nxt  = (w_next_state == HOLD);
    end

    // Request latch and output registers
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            r_dev      <= 2'b00;
            r_write    <= 1'b0;
            A_2D       <= 4'b0000;
            Enable_bar <= 2'b11;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            r_dev      <= w_dev_nxt;
            r_write    <= w_write_nxt;
            A_2D       <= w_a2d_nxt;
            Enable_bar <= w_en_nxt;
            Busy       <= w_busy_nxt;
            Done       <= w_done_nxt;
        end
    end

endmodule
